instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads a one- or two-byte instruction from byte-wide memory,
// advancing a 13-bit pc per accepted byte, with a 15-cycle memory timeout.
module instr_fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic        jump_en,
  input  logic [12:0] jump_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        mem_rd,
  output logic [12:0] mem_addr,
  output logic [12:0] pc,
  output logic [7:0]  ir,
  output logic [7:0]  di,
  output logic [3:0]  opcode,
  output logic        instr_valid,
  output logic        busy,
  output logic        bus_err
);

  // Memory handshake: mem_rd is held while in F1/F2; a byte is taken on any
  // cycle with mem_rd=1 and mem_ack=1. Acks outside F1/F2 are ignored.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_F1    = 2'd1,
    S_F2    = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  di_q, di_d;
  logic [3:0]  wait_q, wait_d;
  logic        bus_err_q, bus_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= 13'd0;
      ir_q      <= 8'd0;
      di_q      <= 8'd0;
      wait_q    <= 4'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      di_q      <= di_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    di_d      = di_q;
    wait_d    = wait_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_IDLE: begin
        // A jump in the same cycle as a fetch lands first, so F1 reads jump_addr.
        if (jump_en) pc_d = jump_addr;
        if (fetch_req) begin
          state_d   = S_F1;
          bus_err_d = 1'b0;
          wait_d    = 4'd0;
        end
      end
      S_F1: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 13'd1;
          wait_d  = 4'd0;
          state_d = (mem_rdata[7:6] == 2'b11) ? S_F2 : S_VALID;
        end else if (wait_q == 4'd14) begin
          wait_d    = 4'd15;
          bus_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_F2: begin
        if (mem_ack) begin
          di_d    = mem_rdata;
          pc_d    = pc_q + 13'd1;
          wait_d  = 4'd0;
          state_d = S_VALID;
        end else if (wait_q == 4'd14) begin
          wait_d    = 4'd15;
          bus_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_VALID: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_rd      = (state_q == S_F1) || (state_q == S_F2);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign di          = di_q;
  assign opcode      = ir_q[7:4];
  assign instr_valid = (state_q == S_VALID);
  assign busy        = (state_q != S_IDLE);
  assign bus_err     = bus_err_q;

endmodule
